counter_bus_master: RTL

- Host-side sequencer that drives the shared 8-bit counter bus: load commands and counter read-backs.
- Converts a simple valid/ready request into the exact pin sequence the counter block needs.
- Load sequence: value on bus, load_now held ≥2 cycles.
- Read sequence: write_now, wait for the counter's registered drive enable, sample, then a bus turnaround gap.
- Sits between the tile's command logic and the counter, and owns the master-side bus output enables.

---
 rtl/counter_bus_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/counter_bus_master.sv
// counter_bus_master: sequences load and read-back transactions on the shared 8-bit counter bus.
// Optional statistics outputs (out_load_count/out_read_count) are enabled by defining COUNTER_BUS_MASTER_STATS_EN.
module counter_bus_master #(
    parameter int LOAD_HOLD = 2,
    parameter int READ_WAIT = 2
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_req_valid,
    input  logic       in_req_op,
    input  logic [7:0] in_req_data,
    output logic       out_req_ready,
    output logic       out_rsp_valid,
    output logic       out_rsp_is_read,
    output logic [7:0] out_rsp_data,
    output logic [7:0] out_bus_value,
    output logic [7:0] out_bus_oe,
    input  logic [7:0] in_bus_value,
    output logic       out_load_now,
    output logic       out_write_now,
`ifdef COUNTER_BUS_MASTER_STATS_EN
    output logic [7:0] out_load_count,
    output logic [7:0] out_read_count,
`endif
    output logic [1:0] out_dbg_state
);

    // Handshake: a request transfers on a rising in_clk edge where in_req_valid && out_req_ready;
    // op/data are sampled only on that edge. Responses are a one-cycle out_rsp_valid pulse with no backpressure.

    localparam int LH    = (LOAD_HOLD < 2) ? 2 : LOAD_HOLD;
    localparam int RW    = (READ_WAIT < 2) ? 2 : READ_WAIT;
    localparam int CMAX  = (LH > RW) ? LH : RW;
    localparam int CNT_W = $clog2(CMAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_TURN    = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             accept;
    logic             load_done;
    logic             read_done;

    logic       rsp_valid_d;
    logic       rsp_is_read_d;
    logic [7:0] rsp_data_d;
    logic [7:0] bus_value_d;
    logic [7:0] bus_oe_d;
    logic       load_now_d;
    logic       write_now_d;
`ifdef COUNTER_BUS_MASTER_STATS_EN
    logic [7:0] load_count_d;
    logic [7:0] read_count_d;
`endif

    // Ready is forced low while reset is asserted so every output reads 0 during reset.
    assign out_req_ready = in_rst_n && (state == ST_IDLE);
    assign out_dbg_state = state;
    assign accept        = in_req_valid && out_req_ready;
    assign load_done     = (cnt == CNT_W'(LH - 1));
    assign read_done     = (cnt == CNT_W'(RW - 1));

    // State register and registered outputs
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            out_rsp_valid   <= 1'b0;
            out_rsp_is_read <= 1'b0;
            out_rsp_data    <= 8'h00;
            out_bus_value   <= 8'h00;
            out_bus_oe      <= 8'h00;
            out_load_now    <= 1'b0;
            out_write_now   <= 1'b0;
`ifdef COUNTER_BUS_MASTER_STATS_EN
            out_load_count  <= 8'h00;
            out_read_count  <= 8'h00;
`endif
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            out_rsp_valid   <= rsp_valid_d;
            out_rsp_is_read <= rsp_is_read_d;
            out_rsp_data    <= rsp_data_d;
            out_bus_value   <= bus_value_d;
            out_bus_oe      <= bus_oe_d;
            out_load_now    <= load_now_d;
            out_write_now   <= write_now_d;
`ifdef COUNTER_BUS_MASTER_STATS_EN
            out_load_count  <= load_count_d;
            out_read_count  <= read_count_d;
`endif
        end
    end

    // Next state; one counter times both the load hold and the read wait
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = in_req_op ? ST_RD_WAIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_RD_WAIT: begin
                if (read_done) begin
                    state_d = ST_TURN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        rsp_valid_d   = 1'b0;
        rsp_is_read_d = out_rsp_is_read;
        rsp_data_d    = out_rsp_data;
        bus_value_d   = out_bus_value;
        bus_oe_d      = out_bus_oe;
        load_now_d    = out_load_now;
        write_now_d   = out_write_now;
`ifdef COUNTER_BUS_MASTER_STATS_EN
        load_count_d  = out_load_count;
        read_count_d  = out_read_count;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_req_op) begin
                        write_now_d = 1'b1;
                    end else begin
                        bus_value_d = in_req_data;
                        bus_oe_d    = 8'hFF;
                        load_now_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    load_now_d    = 1'b0;
                    bus_oe_d      = 8'h00;
                    rsp_valid_d   = 1'b1;
                    rsp_is_read_d = 1'b0;
                    rsp_data_d    = out_bus_value;
`ifdef COUNTER_BUS_MASTER_STATS_EN
                    load_count_d  = out_load_count + 8'd1;
`endif
                end
            end
            ST_RD_WAIT: begin
                // The counter is driving by now; the master's enables stay off
                if (read_done) begin
                    rsp_data_d    = in_bus_value;
                    rsp_valid_d   = 1'b1;
                    rsp_is_read_d = 1'b1;
                    write_now_d   = 1'b0;
`ifdef COUNTER_BUS_MASTER_STATS_EN
                    read_count_d  = out_read_count + 8'd1;
`endif
                end
            end
            default: begin
                bus_oe_d = out_bus_oe;
            end
        endcase
    end

endmodule
